// File: rtl/seg7_pkg.sv
// seg7_pkg: shared display constants, digit index type and hex-to-7-segment decoder.
package seg7_pkg;
   localparam int NUM_DIGITS = 4;
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] ANODE_OFF = 4'hF;
   typedef logic [$clog2(NUM_DIGITS)-1:0] digit_t;
   // Active-low cathodes, bit order {g,f,e,d,c,b,a}
   function automatic logic [6:0] hexdec(input logic [3:0] h);
      case (h)
         4'h0: hexdec = 7'h40;
         4'h1: hexdec = 7'h79;
         4'h2: hexdec = 7'h24;
         4'h3: hexdec = 7'h30;
         4'h4: hexdec = 7'h19;
         4'h5: hexdec = 7'h12;
         4'h6: hexdec = 7'h02;
         4'h7: hexdec = 7'h78;
         4'h8: hexdec = 7'h00;
         4'h9: hexdec = 7'h10;
         4'hA: hexdec = 7'h08;
         4'hB: hexdec = 7'h03;
         4'hC: hexdec = 7'h46;
         4'hD: hexdec = 7'h21;
         4'hE: hexdec = 7'h06;
         default: hexdec = 7'h0E;
      endcase
   endfunction
endpackage

// File: rtl/tick_sync.sv
// tick_sync: synchronises an asynchronous level and emits a one-clock tick per rising edge.
module tick_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic tick
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic delay_q;
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync_q  <= '0;
         delay_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
         delay_q <= sync_q[SYNC_STAGES-1];
      end
   end
   assign tick = sync_q[SYNC_STAGES-1] & ~delay_q;
endmodule

// File: rtl/seg7_scanner.sv
// seg7_scanner: frame-coherent 4-digit common-anode 7-segment multiplexer driven by a scan tick.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg7_scanner
   import seg7_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        scan_clk,
   input  logic [15:0] value,
   input  logic [3:0]  dp_mask,
   input  logic        blank,
   output logic [3:0]  anode,
   output logic [6:0]  segment,
   output logic        dp,
   output logic [1:0]  digit_sel
);
   logic tick, hide;
   digit_t digit_q, digit_d, n;
   logic [15:0] snap_q, snap_d;
   logic [3:0] anode_q, anode_d;
   logic [6:0] seg_q, seg_d;
   logic dp_q, dp_d;
   tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick_sync (
      .clock(clock),
      .reset(reset),
      .async_in(scan_clk),
      .tick(tick)
   );
   always_comb begin
      n = digit_q + 2'd1;
      digit_d = tick ? n : digit_q;
      // New frame: the digit-0 output of this same edge already uses the fresh value
      snap_d = (tick && digit_q == 2'd3) ? value : snap_q;
`ifdef LEADING_ZERO_BLANK_EN
      hide = tick && n != 2'd0 && (snap_d >> {n, 2'b00}) == 16'h0;
`else
      hide = 1'b0;
`endif
      anode_d = (blank || hide) ? ANODE_OFF : tick ? ~(4'b0001 << n) : anode_q;
      seg_d = (blank || hide) ? SEG_BLANK : tick ? hexdec(snap_d[{n, 2'b00} +: 4]) : seg_q;
      dp_d = (blank || hide) ? 1'b1 : tick ? ~dp_mask[n] : dp_q;
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         digit_q <= 2'd3;
         snap_q  <= 16'h0000;
         anode_q <= ANODE_OFF;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         digit_q <= digit_d;
         snap_q  <= snap_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end
   assign anode = anode_q;
   assign segment = seg_q;
   assign dp = dp_q;
   assign digit_sel = digit_q;
endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner: directed stimulus with a frame-level reference model checked every clock.
module tb_seg7_scanner;
   logic clock = 1'b0, reset = 1'b0, scan_clk = 1'b0, blank = 1'b0;
   logic [15:0] value = 16'h0000;
   logic [3:0] dp_mask = 4'h0;
   logic [3:0] anode;
   logic [6:0] segment;
   logic dp;
   logic [1:0] digit_sel;
   int tests = 0, fails = 0;

   seg7_scanner dut (
      .clock(clock), .reset(reset), .scan_clk(scan_clk), .value(value),
      .dp_mask(dp_mask), .blank(blank), .anode(anode), .segment(segment),
      .dp(dp), .digit_sel(digit_sel)
   );

   always #5 clock = ~clock;

   logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
      end
   endtask

   // Reference: a scan_clk rise seen at one edge updates the display two edges later.
   int m_digit;
   logic [15:0] m_snap;
   logic [3:0] m_anode, m_nib;
   logic [6:0] m_seg;
   logic m_dp, prev, r1, r2, ap, hide;
   always @(posedge clock) begin
      if (!reset) begin
         m_digit = 3; m_snap = 16'h0; m_anode = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
         prev = 1'b0; r1 = 1'b0; r2 = 1'b0;
      end else begin
         ap = r2; r2 = r1; r1 = scan_clk & ~prev; prev = scan_clk;
         hide = 1'b0;
         if (ap) begin
            m_digit = (m_digit + 1) % 4;
            if (m_digit == 0) m_snap = value;
            m_nib = 4'(m_snap >> (4 * m_digit));
`ifdef LEADING_ZERO_BLANK_EN
            hide = m_digit != 0 && (m_snap >> (4 * m_digit)) == 16'h0;
`endif
            m_anode = ~(4'(1 << m_digit));
            m_seg = tbl[m_nib];
            m_dp = ~dp_mask[m_digit];
         end
         if (blank || hide) begin
            m_anode = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
         end
      end
   end

   always @(posedge clock) begin
      #1;
      check("model_anode", 16'(anode), 16'(m_anode));
      check("model_segment", 16'(segment), 16'(m_seg));
      check("model_dp", 16'(dp), 16'(m_dp));
      check("model_digit_sel", 16'(digit_sel), 16'(m_digit));
   end

   task automatic scan_pulse(input int hi = 5, input int lo = 4);
      @(negedge clock) scan_clk = 1'b1;
      repeat (hi) @(negedge clock);
      scan_clk = 1'b0;
      repeat (lo) @(negedge clock);
   endtask

   task automatic pulse_check(input string name, input logic [3:0] ea, input logic [6:0] es);
      scan_pulse();
      check({name, "_anode"}, 16'(anode), 16'(ea));
      check({name, "_segment"}, 16'(segment), 16'(es));
   endtask

   logic [3:0] lz_a [8];
   logic [6:0] lz_s [8];

   initial begin
      value = 16'h1A3F;
      for (int i = 0; i < 20; i++) @(negedge clock) scan_clk = ~scan_clk;
      scan_clk = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_anode", 16'(anode), 16'hF);
      check("rst_segment", 16'(segment), 16'h7F);
      check("rst_dp", 16'(dp), 16'h1);
      check("rst_digit_sel", 16'(digit_sel), 16'h3);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      // First tick: update on the 3rd edge sampling scan_clk high
      scan_clk = 1'b1;
      repeat (2) @(posedge clock);
      #1 check("lat_before", 16'(anode), 16'hF);
      @(posedge clock);
      #1 check("lat_at3", 16'(anode), 16'hE);
      check("first_digit_sel", 16'(digit_sel), 16'h0);
      check("first_segment", 16'(segment), 16'h0E);
      repeat (2) @(negedge clock);
      scan_clk = 1'b0;
      repeat (4) @(negedge clock);
      pulse_check("v1A3F_d1", 4'hD, 7'h30);
      pulse_check("v1A3F_d2", 4'hB, 7'h08);
      pulse_check("v1A3F_d3", 4'h7, 7'h79);
      // Frame coherence
      value = 16'h1234;
      pulse_check("coh_d0", 4'hE, 7'h19);
      pulse_check("coh_d1", 4'hD, 7'h30);
      value = 16'h5678;
      pulse_check("coh_d2", 4'hB, 7'h24);
      pulse_check("coh_d3", 4'h7, 7'h79);
      pulse_check("new_d0", 4'hE, 7'h00);
      pulse_check("new_d1", 4'hD, 7'h78);
      pulse_check("new_d2", 4'hB, 7'h02);
      pulse_check("new_d3", 4'h7, 7'h12);
      // Decimal point follows live dp_mask
      dp_mask = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         scan_pulse();
         check("dp_frame", 16'(dp), (i == 2) ? 16'h0 : 16'h1);
      end
      // Blank while ticks keep the digit counter moving
      @(negedge clock) blank = 1'b1;
      @(posedge clock);
      #1 check("blank_anode", 16'(anode), 16'hF);
      scan_pulse(5, 4);
      blank = 1'b0;
      check("blank_digit_sel", 16'(digit_sel), 16'h0);
      check("blank_hold_anode", 16'(anode), 16'hF);
      pulse_check("unblank_d1", 4'hD, 7'h78);
      // scan_clk held high: one tick only
      @(negedge clock) scan_clk = 1'b1;
      repeat (100) @(negedge clock);
      check("stuck_hi_digit_sel", 16'(digit_sel), 16'h2);
      scan_clk = 1'b0;
      repeat (50) @(negedge clock);
      check("stuck_lo_digit_sel", 16'(digit_sel), 16'h2);
      check("stuck_lo_anode", 16'(anode), 16'hB);
      // Reset mid-frame
      reset = 1'b0;
      @(negedge clock);
      check("midrst_anode", 16'(anode), 16'hF);
      check("midrst_digit_sel", 16'(digit_sel), 16'h3);
      value = 16'hBEEF;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      pulse_check("midrst_d0", 4'hE, 7'h0E);
      pulse_check("midrst_d1", 4'hD, 7'h06);
      scan_pulse();
      scan_pulse();
      // Leading zeros
`ifdef LEADING_ZERO_BLANK_EN
      lz_a = '{4'hE, 4'hD, 4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hF};
      lz_s = '{7'h24, 7'h19, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F};
`else
      lz_a = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7};
      lz_s = '{7'h24, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
      value = 16'h0042;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) value = 16'h0000;
         pulse_check("lz", lz_a[i], lz_s[i]);
      end
      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
